// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forwarding control for a 5-stage MIPS pipeline.
// Define HAZARD_FORWARDING_EN for load-use-only stalls with live forward selects.
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [4:0]       ex_rs,
    input  logic [4:0]       ex_rt,
    input  logic [4:0]       ex_dest,
    input  logic             ex_regWrite,
    input  logic             ex_memRead,
    input  logic [4:0]       mem_dest,
    input  logic             mem_regWrite,
    input  logic [4:0]       wb_dest,
    input  logic             wb_regWrite,
    input  logic             branch_taken,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);
    typedef enum logic {RUN, STALL} state_t;
    state_t           r_state, w_state_nxt;
    logic [1:0]       r_stall_left, w_stall_left_nxt;
    logic [CNT_W-1:0] r_stall_cycles, r_flush_events;
    logic [1:0]       w_need;
    logic             w_ex_match;

    function automatic logic f_match(input logic we, input logic [4:0] dest,
                                     input logic [4:0] rs, input logic [4:0] rt,
                                     input logic urs, input logic urt);
        return we && dest != 5'd0 && ((urs && dest == rs) || (urt && dest == rt));
    endfunction

    assign w_ex_match = f_match(ex_regWrite, ex_dest, id_rs, id_rt, id_uses_rs, id_uses_rt);

`ifdef HAZARD_FORWARDING_EN
    logic w_unused;
    assign w_unused = 1'b0;
    assign w_need = {1'b0, w_ex_match && ex_memRead};
    assign fwd_a_sel = !reset ? 2'd0 :
                       (mem_regWrite && mem_dest != 5'd0 && mem_dest == ex_rs) ? 2'd1 :
                       (wb_regWrite && wb_dest != 5'd0 && wb_dest == ex_rs) ? 2'd2 : 2'd0;
    assign fwd_b_sel = !reset ? 2'd0 :
                       (mem_regWrite && mem_dest != 5'd0 && mem_dest == ex_rt) ? 2'd1 :
                       (wb_regWrite && wb_dest != 5'd0 && wb_dest == ex_rt) ? 2'd2 : 2'd0;
`else
    logic w_mem_match, w_wb_match, w_unused;
    assign w_unused    = ^{ex_rs, ex_rt, ex_memRead};
    assign w_mem_match = f_match(mem_regWrite, mem_dest, id_rs, id_rt, id_uses_rs, id_uses_rt);
    assign w_wb_match  = f_match(wb_regWrite, wb_dest, id_rs, id_rt, id_uses_rs, id_uses_rt);
    assign w_need      = w_ex_match ? 2'd3 : w_mem_match ? 2'd2 : w_wb_match ? 2'd1 : 2'd0;
    assign fwd_a_sel   = 2'd0;
    assign fwd_b_sel   = 2'd0;
`endif

    // Outputs are forced to their reset values combinationally while reset is low.
    always_comb begin
        w_state_nxt      = r_state;
        w_stall_left_nxt = r_stall_left;
        pc_write         = 1'b1;
        if_id_write      = 1'b1;
        id_ex_bubble     = 1'b0;
        if_id_flush      = 1'b0;
        id_ex_flush      = 1'b0;
        ex_mem_flush     = 1'b0;
        if (!reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end else if (branch_taken) begin
            if_id_flush      = 1'b1;
            id_ex_flush      = 1'b1;
            ex_mem_flush     = 1'b1;
            w_state_nxt      = RUN;
            w_stall_left_nxt = 2'd0;
        end else if (r_state == STALL) begin
            pc_write         = 1'b0;
            if_id_write      = 1'b0;
            id_ex_bubble     = 1'b1;
            w_stall_left_nxt = r_stall_left - 2'd1;
            w_state_nxt      = (r_stall_left <= 2'd1) ? RUN : STALL;
        end else if (w_need != 2'd0) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            if (w_need >= 2'd2) begin
                w_stall_left_nxt = w_need - 2'd1;
                w_state_nxt      = STALL;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= RUN;
            r_stall_left   <= 2'd0;
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_stall_left <= w_stall_left_nxt;
            if (id_ex_bubble && r_stall_cycles != '1)
                r_stall_cycles <= r_stall_cycles + 1'b1;
            if (branch_taken && r_flush_events != '1)
                r_flush_events <= r_flush_events + 1'b1;
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_events = r_flush_events;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table-driven directed checks of hazard_ctrl in either build.
module tb_hazard_ctrl;
    typedef struct {
        int id_rs, id_rt, urs, urt;
        int exd, exw, exm, exrs, exrt;
        int memd, memw, wbd, wbw, br;
        int pc, ifid, bub, fl, fa, fb;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  id_rs = '0, id_rt = '0, ex_rs = '0, ex_rt = '0, ex_dest = '0, mem_dest = '0, wb_dest = '0;
    logic        id_uses_rs = 0, id_uses_rt = 0, ex_regWrite = 0, ex_memRead = 0;
    logic        mem_regWrite = 0, wb_regWrite = 0, branch_taken = 0;
    logic        pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, ex_mem_flush;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic [15:0] stall_cycles, flush_events;
    int          checks = 0, failures = 0;
    vec_t        tbl[$];
    vec_t        z, h, hb;

    hazard_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest), .ex_regWrite(ex_regWrite),
        .ex_memRead(ex_memRead), .mem_dest(mem_dest), .mem_regWrite(mem_regWrite),
        .wb_dest(wb_dest), .wb_regWrite(wb_regWrite), .branch_taken(branch_taken),
        .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_bubble(id_ex_bubble),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drv(input vec_t v);
        id_rs = 5'(v.id_rs); id_rt = 5'(v.id_rt); id_uses_rs = 1'(v.urs); id_uses_rt = 1'(v.urt);
        ex_dest = 5'(v.exd); ex_regWrite = 1'(v.exw); ex_memRead = 1'(v.exm);
        ex_rs = 5'(v.exrs); ex_rt = 5'(v.exrt); mem_dest = 5'(v.memd); mem_regWrite = 1'(v.memw);
        wb_dest = 5'(v.wbd); wb_regWrite = 1'(v.wbw); branch_taken = 1'(v.br);
    endtask

    task automatic apply(input string tag, input vec_t v);
        @(negedge clk);
        drv(v);
        #1;
        chk({tag, ".pc_write"}, int'(pc_write), v.pc);
        chk({tag, ".if_id_write"}, int'(if_id_write), v.ifid);
        chk({tag, ".bubble"}, int'(id_ex_bubble), v.bub);
        chk({tag, ".flushes"}, int'({if_id_flush, id_ex_flush, ex_mem_flush}), v.fl ? 7 : 0);
        chk({tag, ".fwd_a"}, int'(fwd_a_sel), v.fa);
        chk({tag, ".fwd_b"}, int'(fwd_b_sel), v.fb);
    endtask

    task automatic counters(input string tag, input int sc, input int fe);
        @(negedge clk);
        chk({tag, ".stall_cycles"}, int'(stall_cycles), sc);
        chk({tag, ".flush_events"}, int'(flush_events), fe);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        drv(z);
        reset = 1'b0;
        #1;
        chk({tag, ".pc_write"}, int'(pc_write), 0);
        chk({tag, ".if_id_write"}, int'(if_id_write), 0);
        chk({tag, ".bubble"}, int'(id_ex_bubble), 1);
        chk({tag, ".stall_cycles"}, int'(stall_cycles), 0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        z  = '{0,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 1,1,0,0,0,0};
        h  = '{5,0,1,0, 5,1,1,0,0, 0,0,0,0,0, 0,0,1,0,0,0};
        hb = '{5,0,1,0, 5,1,1,0,0, 0,0,0,0,1, 1,1,0,1,0,0};
`ifdef HAZARD_FORWARDING_EN
        tbl.push_back('{0,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 1,1,0,0,0,0});
        tbl.push_back('{2,4,1,1, 2,1,1,0,0, 0,0,0,0,0, 0,0,1,0,0,0});
        tbl.push_back('{0,0,0,0, 0,0,0,2,4, 0,0,2,1,0, 1,1,0,0,2,0});
        tbl.push_back('{0,0,0,0, 0,0,0,2,2, 2,1,2,1,0, 1,1,0,0,1,1});
        tbl.push_back('{2,0,1,0, 2,1,0,0,0, 0,0,0,0,0, 1,1,0,0,0,0});
        tbl.push_back('{0,0,1,0, 0,1,1,0,0, 0,1,0,1,0, 1,1,0,0,0,0});
        tbl.push_back('{0,8,0,0, 8,1,1,0,0, 0,0,0,0,0, 1,1,0,0,0,0});
        tbl.push_back('{0,0,0,0, 0,0,0,0,5, 5,0,5,1,0, 1,1,0,0,0,2});
        tbl.push_back('{2,0,1,0, 2,1,1,0,0, 0,0,0,0,1, 1,1,0,1,0,0});
        tbl.push_back('{0,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 1,1,0,0,0,0});
`else
        tbl.push_back('{0,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 1,1,0,0,0,0});
        tbl.push_back('{0,0,1,0, 0,1,0,0,0, 0,0,0,0,0, 1,1,0,0,0,0});
        tbl.push_back('{0,7,0,1, 0,0,0,0,0, 0,0,7,1,0, 0,0,1,0,0,0});
        tbl.push_back('{0,7,0,0, 0,0,0,0,0, 0,0,7,1,0, 1,1,0,0,0,0});
        tbl.push_back('{9,0,1,0, 9,0,0,0,0, 0,0,0,0,0, 1,1,0,0,0,0});
        tbl.push_back('{4,0,1,0, 0,0,0,4,4, 4,1,0,0,0, 0,0,1,0,0,0});
        tbl.push_back('{0,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 0,0,1,0,0,0});
        tbl.push_back('{0,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 1,1,0,0,0,0});
        tbl.push_back('{3,6,1,1, 0,0,0,0,0, 3,1,6,1,0, 0,0,1,0,0,0});
        tbl.push_back('{0,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 0,0,1,0,0,0});
        tbl.push_back('{0,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 1,1,0,0,0,0});
        tbl.push_back('{5,0,1,0, 5,1,0,0,0, 0,0,0,0,1, 1,1,0,1,0,0});
        tbl.push_back('{0,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 1,1,0,0,0,0});
`endif
        do_reset("rst0");
        foreach (tbl[i]) apply($sformatf("vec%0d", i), tbl[i]);
`ifdef HAZARD_FORWARDING_EN
        counters("tbl", 1, 1);
`else
        counters("tbl", 5, 1);
        do_reset("rstA");
        apply("raw3.b1", h);
        apply("raw3.b2", '{0,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 0,0,1,0,0,0});
        apply("raw3.b3", '{0,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 0,0,1,0,0,0});
        apply("raw3.run", z);
        counters("raw3", 3, 0);
        apply("brk.b1", h);
        apply("brk.flush", hb);
        apply("brk.run1", z);
        apply("brk.run2", z);
        counters("brk", 4, 1);
`endif
        apply("mid.b1", h);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("mid.pc_write", int'(pc_write), 0);
        chk("mid.if_id_write", int'(if_id_write), 0);
        chk("mid.bubble", int'(id_ex_bubble), 1);
        chk("mid.flushes", int'({if_id_flush, id_ex_flush, ex_mem_flush}), 0);
        chk("mid.stall_cycles", int'(stall_cycles), 0);
        chk("mid.flush_events", int'(flush_events), 0);
        @(negedge clk);
        drv(z);
        reset = 1'b1;
        apply("post.run1", z);
        apply("post.run2", z);
        counters("post", 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
